// File: rtl/arb_pkg.sv
// Shared types and constants for the main-memory arbiter: FSM states,
// requester IDs and the block word-index width helper.
package arb_pkg;

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_SINGLE, DONE} state_t;

  localparam logic REQ_D = 1'b0;
  localparam logic REQ_I = 1'b1;

  localparam int BLOCK_WORDS_DFLT = 4;
  localparam int WIDX_W           = $clog2(BLOCK_WORDS_DFLT);

  function automatic int widx_w(input int bw);
    return $clog2(bw);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Winner selection between the two cache requesters.
// RR_ARB_EN selects round-robin; otherwise the data cache has fixed priority.
module arb_pick
  import arb_pkg::*;
(
  input  logic [1:0] pend,
  input  logic       last_id,
  output logic       win_id
);

`ifdef RR_ARB_EN
  // On a conflict the requester not served last goes next.
  always_comb begin
    win_id = last_id;
    if (&pend)              win_id = ~last_id;
    else if (pend[REQ_D])   win_id = REQ_D;
    else if (pend[REQ_I])   win_id = REQ_I;
  end
`else
  // Win_id is a don't-care with nothing pending, so last_id just fills that slot.
  always_comb begin
    win_id = last_id;
    if (pend[REQ_D])        win_id = REQ_D;
    else if (pend[REQ_I])   win_id = REQ_I;
  end
`endif

endmodule

// File: rtl/main_mem_arbiter.sv
// Serialises D-cache/I-cache block refills and write-throughs onto one memory
// port. Arbitration policy chosen in arb_pick via RR_ARB_EN.
module main_mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           r0_rd,
  input  logic                           r0_wr,
  input  logic [ADDR_W-1:0]              r0_addr,
  input  logic [DATA_W-1:0]              r0_wdata,
  input  logic                           r1_rd,
  input  logic                           r1_wr,
  input  logic [ADDR_W-1:0]              r1_addr,
  input  logic [DATA_W-1:0]              r1_wdata,
  output logic                           r0_gnt,
  output logic                           r0_rvalid,
  output logic                           r0_ready,
  output logic                           r1_gnt,
  output logic                           r1_rvalid,
  output logic                           r1_ready,
  output logic [widx_w(BLOCK_WORDS)-1:0] ridx,
  output logic [DATA_W-1:0]              rdata,
  output logic                           mem_rd,
  output logic                           mem_wr,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  input  logic                           mem_ack
);

  localparam int IW = widx_w(BLOCK_WORDS);

  typedef struct packed {
    logic              id;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t                  state, state_nx;
  req_t                    req_q;
  logic [IW-1:0]           cnt;
  logic                    last_id;
  logic                    win_id;
  logic                    rvalid_q;
  logic [IW-1:0]           ridx_q;
  logic [DATA_W-1:0]       rdata_q;

  logic [1:0]              rd_v, wr_v, pend;
  logic [1:0][ADDR_W-1:0]  addr_v;
  logic [1:0][DATA_W-1:0]  wdata_v;
  logic                    rd_ack, last_word;

  assign rd_v      = {r1_rd, r0_rd};
  assign wr_v      = {r1_wr, r0_wr};
  assign addr_v    = {r1_addr, r0_addr};
  assign wdata_v   = {r1_wdata, r0_wdata};
  assign pend      = rd_v | wr_v;
  assign rd_ack    = (state == RD_BURST) && mem_ack;
  assign last_word = (cnt == IW'(BLOCK_WORDS - 1));

  arb_pick u_pick (
    .pend    (pend),
    .last_id (last_id),
    .win_id  (win_id)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (|pend) state_nx = wr_v[win_id] ? WR_SINGLE : RD_BURST;
      RD_BURST:  if (mem_ack && last_word) state_nx = DONE;
      WR_SINGLE: if (mem_ack) state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      req_q    <= '0;
      cnt      <= '0;
      last_id  <= REQ_I;
      rvalid_q <= 1'b0;
      ridx_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state    <= state_nx;
      rvalid_q <= rd_ack;
      ridx_q   <= rd_ack ? cnt : '0;
      rdata_q  <= rd_ack ? mem_rdata : '0;
      if (state == IDLE) begin
        cnt <= '0;
        if (|pend) req_q <= '{id: win_id, addr: addr_v[win_id], wdata: wdata_v[win_id]};
      end
      if (rd_ack) cnt <= cnt + 1'b1;  // wraps to 0 after the last word
      if (state == DONE) last_id <= req_q.id;
    end
  end

  // Memory side decodes purely from state and latched request.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      RD_BURST: begin
        mem_rd   = 1'b1;
        mem_addr = {req_q.addr[ADDR_W-1:IW], cnt};
      end
      WR_SINGLE: begin
        mem_wr    = 1'b1;
        mem_addr  = req_q.addr;
        mem_wdata = req_q.wdata;
      end
      default: ;
    endcase
  end

  logic [1:0] gnt_v, rvalid_v, ready_v;

  for (genvar i = 0; i < 2; i++) begin : g_req
    assign gnt_v[i]    = (state != IDLE) && (req_q.id == 1'(i));
    assign ready_v[i]  = (state == DONE) && (req_q.id == 1'(i));
    assign rvalid_v[i] = rvalid_q && (req_q.id == 1'(i));
  end

  assign {r1_gnt, r0_gnt}       = gnt_v;
  assign {r1_ready, r0_ready}   = ready_v;
  assign {r1_rvalid, r0_rvalid} = rvalid_v;
  assign ridx                   = ridx_q;
  assign rdata                  = rdata_q;

endmodule
